// File: rtl/acc_req_buffer.sv
// Per-core staging buffer of committed accumulate requests, one FIFO per accumulator.
// Optional macro ACC_REQ_BYPASS_EN: same-cycle push-to-head bypass for an empty FIFO.
module acc_req_buffer #(
  parameter int unsigned N_ACC    = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned GC_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          flush,
  input  logic                                          push_valid,
  input  logic [((N_ACC > 1) ? $clog2(N_ACC) : 1)-1:0]  push_acc,
  input  logic [31:0]                                   push_data,
  input  logic [GC_WIDTH-1:0]                           push_stamp,
  output logic                                          push_ready,
  output logic [N_ACC-1:0]                              out_valid,
  input  logic [N_ACC-1:0]                              out_ready,
  output logic [N_ACC-1:0][31:0]                        out_data,
  output logic [N_ACC-1:0][GC_WIDTH-1:0]                out_stamp,
  output logic                                          empty,
  output logic [N_ACC-1:0][$clog2(DEPTH):0]             occupancy
);

  localparam int unsigned AW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0]         data;
    logic [GC_WIDTH-1:0] stamp;
  } entry_t;

  entry_t        mem    [N_ACC][DEPTH];
  logic [PW-1:0] wr_ptr [N_ACC];
  logic [PW-1:0] rd_ptr [N_ACC];
  logic [CW-1:0] count  [N_ACC];

  logic             push_fire;
  logic [N_ACC-1:0] push_en;
  logic [N_ACC-1:0] wr_en;
  logic [N_ACC-1:0] rd_en;
  entry_t           head;

  // Ready reflects start-of-cycle fullness only; out-of-range targets are never ready.
  always_comb begin
    push_ready = 1'b0;
    for (int i = 0; i < N_ACC; i++) begin
      if ((push_acc == AW'(i)) && (count[i] != CW'(DEPTH))) push_ready = 1'b1;
    end
  end

  assign push_fire = push_valid && push_ready;

  always_comb begin
    push_en = '0;
    wr_en   = '0;
    rd_en   = '0;
    for (int i = 0; i < N_ACC; i++) begin
      push_en[i] = push_fire && (push_acc == AW'(i));
      rd_en[i]   = out_ready[i] && (count[i] != '0);
`ifdef ACC_REQ_BYPASS_EN
      // A bypassed request taken the same cycle is never stored.
      wr_en[i]   = push_en[i] && !((count[i] == '0) && out_ready[i]);
`else
      wr_en[i]   = push_en[i];
`endif
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_stamp = '0;
    occupancy = '0;
    empty     = 1'b1;
    head      = '0;
    for (int i = 0; i < N_ACC; i++) begin
      head         = mem[i][rd_ptr[i]];
      out_valid[i] = (count[i] != '0);
      out_data[i]  = head.data;
      out_stamp[i] = head.stamp;
      occupancy[i] = count[i];
      if (count[i] != '0) empty = 1'b0;
`ifdef ACC_REQ_BYPASS_EN
      if (push_en[i] && (count[i] == '0)) begin
        out_valid[i] = 1'b1;
        out_data[i]  = push_data;
        out_stamp[i] = push_stamp;
      end
`endif
    end
  end

  // Pointer and count state; flush wins over any same-cycle handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ACC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < N_ACC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_ACC; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
        count[i] <= count[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < N_ACC; i++) begin
        if (wr_en[i]) mem[i][wr_ptr[i]] <= {push_data, push_stamp};
      end
    end
  end

  for (genvar gi = 0; gi < N_ACC; gi++) begin : g_count_chk
    a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
      count[gi] <= CW'(DEPTH));
  end

endmodule

// File: tb/tb_acc_req_buffer.sv
// Self-checking bench for acc_req_buffer: directed scenarios plus random traffic
// compared against per-accumulator queue model.
module tb_acc_req_buffer;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic              push_valid;
  logic [1:0]        push_acc;
  logic [31:0]       push_data;
  logic [15:0]       push_stamp;
  logic              push_ready;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [2:0][31:0]  out_data;
  logic [2:0][15:0]  out_stamp;
  logic              empty;
  logic [2:0][2:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] q [3][$];

  acc_req_buffer #(.N_ACC(3), .DEPTH(4), .GC_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .push_valid(push_valid), .push_acc(push_acc), .push_data(push_data),
    .push_stamp(push_stamp), .push_ready(push_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_stamp(out_stamp), .empty(empty), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) q[i].delete();
  endtask

  // One clock of stimulus: drive after negedge, check settled outputs, advance model at posedge.
  task automatic step(input logic pv, input int acc, input logic [31:0] d,
                      input logic [15:0] s, input logic [2:0] ordy, input logic fl);
    logic        exp_pr;
    logic        fire;
    logic        consumed;
    logic        all_empty;
    logic [2:0]  ev;
    logic [47:0] hd [3];
    @(negedge clk);
    push_valid = pv;
    push_acc   = 2'(acc);
    push_data  = d;
    push_stamp = s;
    out_ready  = ordy;
    flush      = fl;
    #1;
    exp_pr    = 1'b0;
    all_empty = 1'b1;
    if (acc < 3) exp_pr = (q[acc].size() < 4);
    fire = pv && exp_pr;
    for (int i = 0; i < 3; i++) begin
      ev[i] = (q[i].size() != 0);
      hd[i] = ev[i] ? q[i][0] : 48'h0;
      if (q[i].size() != 0) all_empty = 1'b0;
    end
`ifdef ACC_REQ_BYPASS_EN
    if (fire && (q[acc].size() == 0)) begin
      ev[acc] = 1'b1;
      hd[acc] = {d, s};
    end
`endif
    chk("push_ready", 64'(push_ready), 64'(exp_pr));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("empty", 64'(empty), 64'(all_empty));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("occupancy[%0d]", i), 64'(occupancy[i]), 64'(q[i].size()));
      if (ev[i]) begin
        chk($sformatf("out_data[%0d]", i), 64'(out_data[i]), 64'(hd[i][47:16]));
        chk($sformatf("out_stamp[%0d]", i), 64'(out_stamp[i]), 64'(hd[i][15:0]));
      end
    end
    @(posedge clk);
    if (fl) begin
      clear_model();
    end else begin
      consumed = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (ev[i] && ordy[i]) begin
          if (q[i].size() > 0) void'(q[i].pop_front());
          else consumed = 1'b1;
        end
      end
      if (fire && !consumed) q[acc].push_back({d, s});
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_acc = 2'd0;
    push_data = '0; push_stamp = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'h0);
    chk("rst empty", 64'(empty), 64'h1);
    chk("rst occupancy", 64'(occupancy), 64'h0);
    chk("rst push_ready", 64'(push_ready), 64'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single push to acc 1, visible next cycle.
    step(1'b1, 1, 32'h3F80_0000, 16'd5, 3'b000, 1'b0);
    step(1'b0, 0, 32'h0, 16'd0, 3'b000, 1'b0);
    chk("t1 out_valid", 64'(out_valid), 64'h2);
    chk("t1 out_data1", 64'(out_data[1]), 64'h3F80_0000);
    chk("t1 occupancy1", 64'(occupancy[1]), 64'h1);
    step(1'b0, 0, 32'h0, 16'd0, 3'b010, 1'b0);

    // Fill acc 0, probe ready per target, drain in order.
    for (int k = 1; k <= 4; k++) step(1'b1, 0, 32'(k * 16), 16'(k), 3'b000, 1'b0);
    step(1'b1, 0, 32'hDEAD, 16'd99, 3'b000, 1'b0);
    step(1'b0, 2, 32'h0, 16'd0, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 0, 32'h0, 16'd0, 3'b001, 1'b0);
    step(1'b0, 0, 32'h0, 16'd0, 3'b000, 1'b0);
    chk("t2 empty", 64'(empty), 64'h1);

    // Full FIFO with push+pop, then push+pop at count 2.
    for (int k = 1; k <= 4; k++) step(1'b1, 0, 32'(k), 16'(k + 10), 3'b000, 1'b0);
    step(1'b1, 0, 32'h55, 16'd55, 3'b001, 1'b0);
    step(1'b0, 0, 32'h0, 16'd0, 3'b001, 1'b0);
    step(1'b1, 0, 32'h66, 16'd66, 3'b001, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 32'h0, 16'd0, 3'b001, 1'b0);

    // Pointer wrap on acc 2.
    for (int k = 0; k < 10; k++) step(1'b1, 2, 32'(k), 16'(k + 100), 3'b100, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 2, 32'h0, 16'd0, 3'b100, 1'b0);

    // Flush overriding a concurrent push and pop.
    step(1'b1, 0, 32'hA0, 16'd1, 3'b000, 1'b0);
    step(1'b1, 1, 32'hA1, 16'd2, 3'b000, 1'b0);
    step(1'b1, 2, 32'hA2, 16'd3, 3'b000, 1'b0);
    step(1'b1, 0, 32'hA3, 16'd4, 3'b111, 1'b1);
    step(1'b0, 0, 32'h0, 16'd0, 3'b000, 1'b0);
    chk("flush empty", 64'(empty), 64'h1);

    // Asynchronous reset between edges.
    step(1'b1, 1, 32'hB0, 16'd7, 3'b000, 1'b0);
    step(1'b1, 2, 32'hB1, 16'd8, 3'b000, 1'b0);
    @(negedge clk);
    push_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'h0);
    chk("async empty", 64'(empty), 64'h1);
    chk("async occupancy", 64'(occupancy), 64'h0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;

    // Push to empty acc 1 with ready high (bypass behaviour when enabled).
    step(1'b1, 1, 32'hC0, 16'd9, 3'b010, 1'b0);
    step(1'b0, 1, 32'h0, 16'd0, 3'b010, 1'b0);

    // Random traffic, including invalid accumulator index 3.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom,
           16'($urandom), 3'($urandom), $urandom_range(0, 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_req_buffer.md
Name: acc_req_buffer

Overview:
- Per-core staging buffer between a core's commit stage and the shared accumulator (FPR fadd) arbiter in the parent register file.
- Holds committed accumulate requests (32-bit addend plus global-counter stamp), one FIFO per accumulator.
- Presents each FIFO head on a valid/ready channel to the arbiter, which picks among cores by stamp.
- Lets the core keep committing while the arbiter serves other cores.

Parameters:
- N_ACC, 3, number of accumulators; one FIFO each.
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- GC_WIDTH, 16, width of the global-counter stamp.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFOs (misspeculation / fork restart).
- push_valid  in  1  commit stage offers one request this cycle.
- push_acc  in  $clog2(N_ACC)  target accumulator index.
- push_data  in  32  addend (IEEE single).
- push_stamp  in  GC_WIDTH  signed global-counter stamp of the committing instruction.
- push_ready  out  1  FIFO[push_acc] can accept.
- out_valid  out  [N_ACC]  FIFO i head valid.
- out_ready  in  [N_ACC]  arbiter accepts head i.
- out_data  out  [N_ACC][32]  head addend of FIFO i.
- out_stamp  out  [N_ACC][GC_WIDTH]  head stamp of FIFO i.
- empty  out  1  all FIFOs empty; used for the no-pending-request check.
- occupancy  out  [N_ACC][$clog2(DEPTH)+1]  entry count per FIFO.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and counts go to 0.
  - out_valid = 0, empty = 1, occupancy = 0, push_ready = 1.
  - Storage contents are not reset.
- Per-FIFO state:
  - wr_ptr, rd_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count: $clog2(DEPTH)+1 bits.
  - full = (count == DEPTH).
- push_ready:
  - Equals !full of FIFO[push_acc] at the start of the cycle.
  - A same-cycle pop does not free a slot.
  - No combinational path from out_ready to push_ready.
- Push fires when push_valid && push_ready. On fire: write {data, stamp} at wr_ptr, wr_ptr+1, count+1.
- push_acc >= N_ACC: push_ready = 0; request never accepted.
- Pop of FIFO i fires when out_valid[i] && out_ready[i]: rd_ptr+1, count-1.
- Head outputs:
  - out_valid[i] = (count != 0).
  - out_data / out_stamp read combinationally from storage at rd_ptr.
  - Stable while valid && !ready.
- Latency: an entry pushed at edge t is visible on out_* after edge t (one cycle).
- Simultaneous push and pop on the same FIFO (not full): both occur; count unchanged.
- Simultaneous push and pop on a full FIFO: push refused, pop occurs.
- Ordering:
  - Strict FIFO per accumulator.
  - No ordering between different accumulators.
  - Stamps are passed through unmodified; no arithmetic on them.
- flush (synchronous, high):
  - Next cycle: all counts and pointers = 0.
  - flush overrides a same-cycle push and pop; the arbiter must ignore that cycle's handshake result.
- reset_n asserted mid-transfer: the entry is lost, not delivered.
- empty = AND over i of (count[i] == 0), registered-state derived.
- occupancy[i] = count[i].
- Assertion: count never exceeds DEPTH.

Optional Feature:
- Macro: ACC_REQ_BYPASS_EN.
- Defined: when FIFO[push_acc] is empty and push fires, the request appears on out_* in the same cycle, combinationally from push_*.
  - If out_ready is also high that cycle, the entry is consumed without being written (count stays 0).
  - Otherwise it is written normally.
  - push_ready is unchanged.
- Not defined: the one-cycle latency above holds and there is no push-to-out combinational path.

Test Plan:
- Reset, then push acc=1 data=0x3F800000 stamp=5 with out_ready=0 -> next cycle out_valid=3'b010, out_data[1]=0x3F800000, out_stamp[1]=5, empty=0, occupancy[1]=1.
- Push 4 entries to acc=0 (stamps 1..4) with out_ready=0 -> push_ready=0 while push_acc=0 and =1 when push_acc=2; release out_ready[0] -> stamps 1,2,3,4 in order over 4 cycles, then empty=1.
- FIFO0 full plus same-cycle push and pop -> push refused, count 4->3; at count=2, push and pop together -> count stays 2, stamp order preserved.
- Pointer wrap: 10 push/pop pairs on acc=2 with data 0..9 -> data out 0..9 in order, never duplicated or dropped.
- flush with 3 entries spread over acc 0/1/2 plus a concurrent push -> next cycle out_valid=0, empty=1; reset_n pulsed low mid-stream asynchronously -> outputs clear without a clock edge.
- ACC_REQ_BYPASS_EN: push to empty acc=1 with out_ready[1]=1 -> out_valid[1]=1 the same cycle, occupancy[1] stays 0; without the macro -> out_valid[1] rises one cycle later.
